// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side bus of the unified memory port arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ready,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ready,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one variable-latency memory.
// Optional grant timeout/abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FETCH_FIRST = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          owner,
    output logic                stall,
    output logic                err
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam logic DATA_WINS = (FETCH_FIRST == 0);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be within 2..65535");
    end

    state_t state;
    logic   i_elig;
    logic   d_elig;
    logic   pick_i;
    logic   pick_d;

    // A port whose ready is still high has not dropped its old request.
    assign i_elig = bus.if_req & ~bus.if_ready;
    assign d_elig = bus.d_req & ~bus.d_ready;
    assign pick_d = d_elig & (DATA_WINS | ~i_elig);
    assign pick_i = i_elig & ~pick_d;
    assign stall  = i_elig | d_elig;
    assign owner  = state;

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] ABORT32 = 32'hDEAD_BEEF;
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT32);
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;
    logic        timeout_hit;

    assign timeout_hit = (cnt == LAST_CNT);
`else
    assign err = 1'b0;
`endif

    // Grant FSM: issue one memory access, hold it, return a ready pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_ready  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ready   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt           <= '0;
            err           <= 1'b0;
`endif
        end else begin
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        state         <= GRANT_D;
                    end else if (pick_i) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        state         <= GRANT_I;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                GRANT_I, GRANT_D: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (state == GRANT_I) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_ready <= 1'b1;
                        end else begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_ready <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        err         <= 1'b1;
                        if (state == GRANT_I) begin
                            bus.if_rdata <= ABORT_DATA;
                            bus.if_ready <= 1'b1;
                        end else begin
                            bus.d_rdata <= ABORT_DATA;
                            bus.d_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory.
// Build with +define+ARB_TIMEOUT_EN to exercise the grant timeout.
module tb_mem_port_arbiter;
    typedef struct {
        logic [31:0] data;
        bit          care;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] owner;
    logic       stall;
    logic       err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FETCH_FIRST(0), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .owner(owner), .stall(stall), .err(err)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_i[$];
    exp_t exp_d[$];

    logic [31:0] memv [logic [31:0]];
    int          lat        = 0;
    bit          manual_mem = 1'b0;
    logic        man_rdy    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.care = 1'b1;
        exp_i.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] d, input bit care);
        exp_t e;
        e.data = d;
        e.care = care;
        exp_d.push_back(e);
    endtask

    task automatic wait_rdy(input bit is_d, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (is_d ? bus.d_ready : bus.if_ready) break;
            if (cyc >= 200) begin
                chk(is_d ? "d_ready_timeout" : "if_ready_timeout",
                    32'(is_d ? bus.d_ready : bus.if_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        int c;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        push_i(d);
        wait_rdy(1'b0, c);
        bus.if_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        int c;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = a;
        push_d(d, 1'b1);
        wait_rdy(1'b1, c);
        bus.d_req = 1'b0;
    endtask

    // Memory: answers after lat wait cycles, or replays man_rdy in manual mode.
    initial begin
        int mcnt;
        mcnt          = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (manual_mem) begin
                bus.mem_ready = man_rdy;
                bus.mem_rdata = 32'h5A5A_5A5A;
                mcnt = 0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                mcnt = 0;
            end else if (bus.mem_req === 1'b1) begin
                mcnt++;
                if (mcnt > lat) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        memv[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = 32'h0BAD_0BAD;
                    end else begin
                        bus.mem_rdata = memv[bus.mem_addr];
                    end
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_ready === 1'b1) begin
                if (exp_i.size() == 0) begin
                    chk("if_ready_unexpected", 32'(bus.if_ready), 32'd0);
                end else begin
                    e = exp_i.pop_front();
                    chk("if_rdata", bus.if_rdata, e.data);
                end
            end
            if (bus.d_ready === 1'b1) begin
                if (exp_d.size() == 0) begin
                    chk("d_ready_unexpected", 32'(bus.d_ready), 32'd0);
                end else begin
                    e = exp_d.pop_front();
                    if (e.care) chk("d_rdata", bus.d_rdata, e.data);
                end
            end
        end
    end

    initial begin
        int cyc;
        int sbad;
        int hi;
        memv[32'h100] = 32'h1111_2222;
        memv[32'h040] = 32'h2008_0005;
        memv[32'h044] = 32'h8C09_0000;
        memv[32'h060] = 32'hCAFE_F00D;

        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        lat = 0;
        push_i(32'h1111_2222);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_mem_req", 32'(bus.mem_req), 32'd1);
        chk("rel_mem_addr", bus.mem_addr, 32'h100);
        chk("rel_owner", 32'(owner), 32'd1);
        wait_rdy(1'b0, cyc);
        @(negedge clk);
        chk("held_no_reissue", 32'(bus.mem_req), 32'd0);
        chk("held_owner", 32'(owner), 32'd0);
        chk("held_single_pulse", 32'(bus.if_ready), 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("drop_owner", 32'(owner), 32'd0);
        chk("drop_mem_req", 32'(bus.mem_req), 32'd0);

        lat = 3;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        push_i(32'h2008_0005);
        cyc  = 0;
        sbad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.if_ready || cyc >= 200) break;
            if (!stall) sbad++;
        end
        chk("fetch_latency", 32'(cyc), 32'd5);
        chk("fetch_stall_pending", 32'(sbad), 32'd0);
        chk("fetch_stall_ready", 32'(stall), 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_one_pulse", 32'(bus.if_ready), 32'd0);

        lat = 1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h54;
        bus.d_wdata = 32'h7;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        push_d(32'h0, 1'b0);
        push_i(32'h8C09_0000);
        @(negedge clk);
        chk("sim_owner_d", 32'(owner), 32'd2);
        chk("sim_mem_we", 32'(bus.mem_we), 32'd1);
        chk("sim_mem_addr_d", bus.mem_addr, 32'h54);
        chk("sim_mem_wdata", bus.mem_wdata, 32'h7);
        wait_rdy(1'b1, cyc);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        chk("sim_owner_i", 32'(owner), 32'd1);
        chk("sim_fetch_we", 32'(bus.mem_we), 32'd0);
        chk("sim_mem_addr_i", bus.mem_addr, 32'h44);
        chk("sim_fetch_wdata", bus.mem_wdata, 32'h0);
        wait_rdy(1'b0, cyc);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("sim_owner_idle", 32'(owner), 32'd0);

        lat = 2;
        do_fetch(32'h54, 32'h7);
        do_load(32'h60, 32'hCAFE_F00D);
        @(negedge clk);

        manual_mem  = 1'b1;
        man_rdy     = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h80;
        @(negedge clk);
        chk("mid_owner_d", 32'(owner), 32'd2);
        chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
        reset     = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 man_rdy = 1'b1;
        @(posedge clk);
        #1 man_rdy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_d_ready", 32'(bus.d_ready), 32'd0);
            chk("mid_idle", 32'(owner), 32'd0);
        end
        chk("mid_mem_req_idle", 32'(bus.mem_req), 32'd0);

`ifdef ARB_TIMEOUT_EN
        push_d(32'hDEAD_BEEF, 1'b1);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h90;
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.mem_req) hi++;
            else if (hi > 0) break;
        end
        chk("to_grant_cycles", 32'(hi), 32'd8);
        chk("to_d_ready", 32'(bus.d_ready), 32'd1);
        chk("to_err_set", 32'(err), 32'd1);
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_owner_idle", 32'(owner), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", 32'(err), 32'd0);
        reset = 1'b1;
`else
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h90;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_req) hi++;
        end
        chk("nto_grant_cycles", 32'(hi), 32'd20);
        chk("nto_owner_d", 32'(owner), 32'd2);
        chk("nto_err", 32'(err), 32'd0);
        chk("nto_d_ready", 32'(bus.d_ready), 32'd0);
        reset     = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("nto_rst_owner", 32'(owner), 32'd0);
        reset = 1'b1;
`endif
        manual_mem = 1'b0;
        repeat (3) @(negedge clk);
        chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
        chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
